mdio_link_poller: RTL and testbench
===================================

Name: mdio_link_poller

Overview:
- Bus-side front end placed between the picosoc iomem bus and the memory-mapped MDIO master.
- Passes CPU MDIO accesses (addr[31:24]=8'h07) through to the MDIO master unchanged.
- Autonomously reads the PHY BMSR (register 1) at a fixed interval and tracks link and autonegotiation state.
- Raises a sticky interrupt on any link change and exposes a local status/control register window at addr[31:24]=8'h08.

Parameters:
- PHY_ID, 5'd0: PHY address used for autonomous BMSR polls.
- POLL_CYCLES, 24'd1000000: clk cycles between poll launches.
- TIMEOUT_CYCLES, 16'd20000: watchdog limit on one MDIO transaction. Used only with the optional feature.

Ports:
- clk  in  1: system clock.
- rst  in  1: synchronous active-high reset.
- s_valid  in  1: CPU iomem valid.
- s_ready  out  1: CPU iomem ready, one-cycle pulse.
- s_wstrb  in  4: CPU byte strobes; 0 means read.
- s_addr  in  32: CPU address.
- s_wdata  in  32: CPU write data.
- s_rdata  out  32: CPU read data, valid while s_ready=1.
- m_valid  out  1: to MDIO master iomem_valid.
- m_ready  in  1: from MDIO master iomem_ready, one-cycle pulse.
- m_wstrb  out  4: to MDIO master.
- m_addr  out  32: to MDIO master.
- m_wdata  out  32: to MDIO master.
- m_rdata  in  32: from MDIO master.
- link_up  out  1: registered BMSR[2] from the last successful poll.
- irq  out  1: level; equals the sticky link_changed bit AND irq_en.

Behaviour:
- Reset: every output is 0. poll_enable=1, irq_en=0, timer=0, poll_pending=0, FSM=IDLE, status bits=0.
- Poll timer: counts up while poll_enable=1. At POLL_CYCLES-1 it wraps to 0 and sets poll_pending. It holds at 0 while poll_enable=0. A new expiry while a poll is pending or in flight is merged into the existing poll (no queueing).
- FSM states: IDLE, CPU_XFER, POLL_XFER, LOCAL_RESP, HALT.
- IDLE arbitration, highest priority first:
  1. s_valid with addr 8'h08 -> LOCAL_RESP.
  2. poll_pending -> POLL_XFER. A poll beats a simultaneous CPU MDIO request; the CPU request waits with s_ready low.
  3. s_valid with addr 8'h07 -> CPU_XFER.
- Other s_addr values are ignored; s_ready stays 0.
- CPU_XFER:
  - m_addr, m_wstrb and m_wdata are registered from the s_ bus on entry, and m_valid=1 the cycle after entry.
  - On the cycle m_ready=1: m_valid<=0, s_ready<=1 for one cycle, s_rdata<=m_rdata, return to IDLE.
  - m_valid is always low on the cycle after m_ready; the MDIO master re-arms on that cycle.
- POLL_XFER:
  - Drives m_addr = {8'h07, 11'b0, PHY_ID, 1'b0, 5'd1, 2'b00} with m_wstrb=0.
  - On m_ready: bmsr = {m_rdata[7:0], m_rdata[15:8]} (undoes the master's byte swap). link_up<=bmsr[2], aneg_done<=bmsr[5], last_bmsr<=bmsr.
  - If the new link_up differs from the previous value, link_changed<=1.
  - Clears poll_pending, returns to IDLE, and never drives s_ready.
- LOCAL_RESP: one cycle, s_ready=1.
  - Offset 0x00 STATUS, read: [0] link_up, [1] aneg_done, [2] link_changed, [3] timeout_err, [31:16] last_bmsr.
  - Offset 0x00 STATUS, write with wstrb[0]=1: writing 1 to bit 2 or bit 3 clears that bit (W1C).
  - Offset 0x04 CTRL, read/write: [0] poll_enable, [1] irq_en. A write with wstrb[0]=1 also clears the timer and poll_pending when poll_enable is written to 0.
  - Other offsets read 0 and ignore writes.
- A link_changed set and a W1C clear in the same cycle: the set wins.
- Mid-operation reset: m_valid drops on the next edge. The MDIO master's late ready pulse lands in IDLE and is ignored, since m_valid=0.

Optional Feature:
- Macro: MDIO_POLL_TIMEOUT_EN.
- With the macro: a 16-bit counter runs during CPU_XFER and POLL_XFER. When it reaches TIMEOUT_CYCLES:
  - m_valid<=0 and timeout_err<=1.
  - For a CPU_XFER, s_ready pulses with s_rdata=32'hFFFF_FFFF.
  - The FSM enters HALT. In HALT only LOCAL_RESP is served, and any m_ready is ignored.
  - A W1C of timeout_err returns the FSM to IDLE.
- Without the macro: there is no counter and no HALT state, transfers wait indefinitely, and timeout_err reads 0.

Test Plan:
- CPU read addr 32'h0700_0104, model returns m_rdata=32'h0000_2D78 -> exactly one m_valid transaction and one s_ready pulse with s_rdata=32'h0000_2D78. m_valid is low the cycle after m_ready.
- POLL_CYCLES=100, model BMSR=16'h782D -> poll issued at cycle 100, m_addr=32'h0700_0004, m_wstrb=0. Afterwards link_up=1, aneg_done=1, STATUS[31:16]=16'h782D.
- Second poll with BMSR=16'h7809 -> link_up falls to 0 and link_changed=1. With irq_en=1, irq=1. A write of 32'h4 to 32'h0800_0000 clears irq the next cycle.
- CPU request at 8'h07 on the same cycle poll_pending rises -> the poll transfer completes first, then the CPU transfer, with s_ready pulsing once.
- CTRL write 0 at 32'h0800_0004, then 3*POLL_CYCLES idle -> no m_valid asserted.
- With MDIO_POLL_TIMEOUT_EN, model never returns ready on a CPU read -> s_ready with 32'hFFFF_FFFF after TIMEOUT_CYCLES and STATUS[3]=1. The next 8'h07 access is stalled until the W1C of bit 3.

Source files
------------

// File: rtl/mdio_link_poller.sv
// Bus front end for the MDIO master: CPU pass-through, autonomous BMSR polling, link IRQ.
// Optional transaction watchdog and HALT state: define MDIO_POLL_TIMEOUT_EN.
module mdio_link_poller #(
    parameter logic [4:0]  PHY_ID         = 5'd0,
    parameter logic [23:0] POLL_CYCLES    = 24'd1000000,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd20000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [3:0]  s_wstrb,
    input  logic [31:0] s_addr,
    input  logic [31:0] s_wdata,
    output logic [31:0] s_rdata,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [3:0]  m_wstrb,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    output logic        link_up,
    output logic        irq
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CPU   = 3'd1;
    localparam logic [2:0] S_POLL  = 3'd2;
    localparam logic [2:0] S_LOCAL = 3'd3;
`ifdef MDIO_POLL_TIMEOUT_EN
    localparam logic [2:0] S_HALT  = 3'd4;
`endif

    localparam logic [31:0] POLL_ADDR =
        {8'h07, 11'b0, PHY_ID, 1'b0, 5'd1, 2'b00};

    logic [2:0]  state_q, state_d;
    logic [23:0] timer_q, timer_d;
    logic        poll_pending_q, poll_pending_d;
    logic        poll_enable_q, poll_enable_d;
    logic        irq_en_q, irq_en_d;
    logic        link_up_q, link_up_d;
    logic        aneg_done_q, aneg_done_d;
    logic        link_changed_q, link_changed_d;
    logic        timeout_err_q, timeout_err_d;
    logic [15:0] last_bmsr_q, last_bmsr_d;
    logic        m_valid_q, m_valid_d;
    logic [31:0] m_addr_q, m_addr_d;
    logic [3:0]  m_wstrb_q, m_wstrb_d;
    logic [31:0] m_wdata_q, m_wdata_d;
    logic        s_ready_q, s_ready_d;
    logic [31:0] s_rdata_q, s_rdata_d;

`ifdef MDIO_POLL_TIMEOUT_EN
    logic [15:0] tmo_q, tmo_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    logic [15:0] bmsr;
    logic        local_sel, cpu_sel, local_go, idle_like;
    logic [31:0] local_rdata;

    always_comb begin
        bmsr = {m_rdata[7:0], m_rdata[15:8]};
        // s_ready_q blocks re-accepting a request the CPU has not yet dropped
        local_sel = s_valid && !s_ready_q && (s_addr[31:24] == 8'h08);
        cpu_sel   = s_valid && !s_ready_q && (s_addr[31:24] == 8'h07);
`ifdef MDIO_POLL_TIMEOUT_EN
        idle_like = (state_q == S_IDLE) || (state_q == S_HALT);
`else
        idle_like = (state_q == S_IDLE);
`endif
        local_go = local_sel && idle_like;
        unique case (s_addr[23:0])
            24'h000000: local_rdata = {last_bmsr_q, 12'd0, timeout_err_q,
                                       link_changed_q, aneg_done_q, link_up_q};
            24'h000004: local_rdata = {30'd0, irq_en_q, poll_enable_q};
            default:    local_rdata = 32'd0;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        timer_d        = timer_q;
        poll_pending_d = poll_pending_q;
        poll_enable_d  = poll_enable_q;
        irq_en_d       = irq_en_q;
        link_up_d      = link_up_q;
        aneg_done_d    = aneg_done_q;
        link_changed_d = link_changed_q;
        timeout_err_d  = timeout_err_q;
        last_bmsr_d    = last_bmsr_q;
        m_valid_d      = m_valid_q;
        m_addr_d       = m_addr_q;
        m_wstrb_d      = m_wstrb_q;
        m_wdata_d      = m_wdata_q;
        s_ready_d      = 1'b0;
        s_rdata_d      = s_rdata_q;
`ifdef MDIO_POLL_TIMEOUT_EN
        tmo_d          = tmo_q;
`endif

        if (!poll_enable_q) begin
            timer_d = 24'd0;
        end else if (timer_q == POLL_CYCLES - 24'd1) begin
            timer_d        = 24'd0;
            poll_pending_d = 1'b1;
        end else begin
            timer_d = timer_q + 24'd1;
        end

        if (local_go) begin
            state_d   = S_LOCAL;
            s_ready_d = 1'b1;
            s_rdata_d = local_rdata;
            if (s_wstrb[0]) begin
                if (s_addr[23:0] == 24'h000000) begin
                    if (s_wdata[2]) link_changed_d = 1'b0;
                    if (s_wdata[3]) timeout_err_d  = 1'b0;
                end else if (s_addr[23:0] == 24'h000004) begin
                    poll_enable_d = s_wdata[0];
                    irq_en_d      = s_wdata[1];
                    if (!s_wdata[0]) begin
                        timer_d        = 24'd0;
                        poll_pending_d = 1'b0;
                    end
                end
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (local_go) begin
                    state_d = S_LOCAL;
                end else if (poll_pending_q) begin
                    state_d   = S_POLL;
                    m_valid_d = 1'b1;
                    m_addr_d  = POLL_ADDR;
                    m_wstrb_d = 4'd0;
                    m_wdata_d = 32'd0;
`ifdef MDIO_POLL_TIMEOUT_EN
                    tmo_d     = 16'd0;
`endif
                end else if (cpu_sel) begin
                    state_d   = S_CPU;
                    m_valid_d = 1'b1;
                    m_addr_d  = s_addr;
                    m_wstrb_d = s_wstrb;
                    m_wdata_d = s_wdata;
`ifdef MDIO_POLL_TIMEOUT_EN
                    tmo_d     = 16'd0;
`endif
                end
            end
            S_CPU: begin
                if (m_ready) begin
                    state_d   = S_IDLE;
                    m_valid_d = 1'b0;
                    s_ready_d = 1'b1;
                    s_rdata_d = m_rdata;
                end
`ifdef MDIO_POLL_TIMEOUT_EN
                else if (tmo_q == TIMEOUT_CYCLES) begin
                    state_d       = S_HALT;
                    m_valid_d     = 1'b0;
                    timeout_err_d = 1'b1;
                    s_ready_d     = 1'b1;
                    s_rdata_d     = 32'hFFFF_FFFF;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
`endif
            end
            S_POLL: begin
                if (m_ready) begin
                    state_d        = S_IDLE;
                    m_valid_d      = 1'b0;
                    link_up_d      = bmsr[2];
                    aneg_done_d    = bmsr[5];
                    last_bmsr_d    = bmsr;
                    poll_pending_d = 1'b0;
                    if (bmsr[2] != link_up_q) link_changed_d = 1'b1;
                end
`ifdef MDIO_POLL_TIMEOUT_EN
                else if (tmo_q == TIMEOUT_CYCLES) begin
                    state_d        = S_HALT;
                    m_valid_d      = 1'b0;
                    timeout_err_d  = 1'b1;
                    poll_pending_d = 1'b0;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
`endif
            end
            S_LOCAL: begin
`ifdef MDIO_POLL_TIMEOUT_EN
                state_d = timeout_err_q ? S_HALT : S_IDLE;
`else
                state_d = S_IDLE;
`endif
            end
`ifdef MDIO_POLL_TIMEOUT_EN
            S_HALT: begin
                if (local_go) state_d = S_LOCAL;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            timer_q        <= 24'd0;
            poll_pending_q <= 1'b0;
            poll_enable_q  <= 1'b1;
            irq_en_q       <= 1'b0;
            link_up_q      <= 1'b0;
            aneg_done_q    <= 1'b0;
            link_changed_q <= 1'b0;
            timeout_err_q  <= 1'b0;
            last_bmsr_q    <= 16'd0;
            m_valid_q      <= 1'b0;
            m_addr_q       <= 32'd0;
            m_wstrb_q      <= 4'd0;
            m_wdata_q      <= 32'd0;
            s_ready_q      <= 1'b0;
            s_rdata_q      <= 32'd0;
`ifdef MDIO_POLL_TIMEOUT_EN
            tmo_q          <= 16'd0;
`endif
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            poll_pending_q <= poll_pending_d;
            poll_enable_q  <= poll_enable_d;
            irq_en_q       <= irq_en_d;
            link_up_q      <= link_up_d;
            aneg_done_q    <= aneg_done_d;
            link_changed_q <= link_changed_d;
            timeout_err_q  <= timeout_err_d;
            last_bmsr_q    <= last_bmsr_d;
            m_valid_q      <= m_valid_d;
            m_addr_q       <= m_addr_d;
            m_wstrb_q      <= m_wstrb_d;
            m_wdata_q      <= m_wdata_d;
            s_ready_q      <= s_ready_d;
            s_rdata_q      <= s_rdata_d;
`ifdef MDIO_POLL_TIMEOUT_EN
            tmo_q          <= tmo_d;
`endif
        end
    end

    assign s_ready = s_ready_q;
    assign s_rdata = s_rdata_q;
    assign m_valid = m_valid_q;
    assign m_addr  = m_addr_q;
    assign m_wstrb = m_wstrb_q;
    assign m_wdata = m_wdata_q;
    assign link_up = link_up_q;
    assign irq     = link_changed_q & irq_en_q;

endmodule

// File: tb/tb_mdio_link_poller.sv
// Directed bench for mdio_link_poller with a small MDIO master model.
// Timeout checks are built only when MDIO_POLL_TIMEOUT_EN is defined.
module tb_mdio_link_poller;

    localparam logic [23:0] PC = 24'd100;
    localparam logic [15:0] TO = 16'd50;
    localparam logic [31:0] STATUS = 32'h0800_0000;
    localparam logic [31:0] CTRL   = 32'h0800_0004;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid, s_ready;
    logic [3:0]  s_wstrb;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic        m_valid, m_ready;
    logic [3:0]  m_wstrb;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic        link_up, irq;

    mdio_link_poller #(
        .PHY_ID(5'd0), .POLL_CYCLES(PC), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_wstrb(s_wstrb),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(s_rdata),
        .m_valid(m_valid), .m_ready(m_ready), .m_wstrb(m_wstrb),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
        .link_up(link_up), .irq(irq)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // MDIO master model: answers after 4 cycles of m_valid
    logic [15:0] bmsr_m = 16'h782D;
    logic [31:0] cpu_m  = 32'd0;
    bit   resp_en = 1'b1;
    bit   late_pulse = 1'b0;
    int   wait_cnt = 0, poll_cnt = 0, cpu_cnt = 0, sr_cnt = 0;
    int   mv_viol = 0, cpu_poll_mark = 0;
    logic [31:0] cpu_addr_seen = '0, cpu_wdata_seen = '0;
    logic [3:0]  cpu_wstrb_seen = '0;

    initial begin
        m_ready = 1'b0;
        m_rdata = 32'd0;
        forever begin
            @(posedge clk); #1;
            if (m_ready && m_valid) mv_viol++;
            m_ready = 1'b0;
            if (late_pulse) begin
                late_pulse = 1'b0;
                m_ready = 1'b1;
                m_rdata = 32'hDEAD_BEEF;
            end else if (m_valid && resp_en) begin
                if (wait_cnt == 3) begin
                    wait_cnt = 0;
                    m_ready = 1'b1;
                    if (m_wstrb == 4'd0 && m_addr == 32'h0700_0004) begin
                        m_rdata = {16'h0, bmsr_m[7:0], bmsr_m[15:8]};
                        poll_cnt++;
                    end else begin
                        m_rdata = cpu_m;
                        cpu_cnt++;
                        cpu_poll_mark = poll_cnt;
                        cpu_addr_seen = m_addr;
                        cpu_wdata_seen = m_wdata;
                        cpu_wstrb_seen = m_wstrb;
                    end
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (s_ready) sr_cnt++;
        end
    end

    task automatic bus(input logic [31:0] a, input logic [3:0] ws,
                       input logic [31:0] wd, input int budget,
                       output logic [31:0] rd, output bit ok);
        @(negedge clk);
        s_valid = 1'b1; s_addr = a; s_wstrb = ws; s_wdata = wd;
        ok = 1'b0; rd = '0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #2;
            if (s_ready) begin
                rd = s_rdata;
                ok = 1'b1;
                break;
            end
        end
        s_valid = 1'b0; s_wstrb = 4'd0;
    endtask

    task automatic rd32(input string tag, input logic [31:0] a,
                        output logic [31:0] d);
        bit ok;
        bus(a, 4'd0, 32'd0, 400, d, ok);
        chk({tag, "_ack"}, {31'd0, ok}, 32'd1);
    endtask

    task automatic wr32(input string tag, input logic [31:0] a,
                        input logic [31:0] d);
        bit ok;
        logic [31:0] unused_rd;
        bus(a, 4'hF, d, 400, unused_rd, ok);
        chk({tag, "_ack"}, {31'd0, ok}, 32'd1);
    endtask

    initial begin
        int n, p0, s0, c0;
        logic [31:0] d;
        bit ok;
        rst = 1'b1; s_valid = 1'b0; s_addr = '0; s_wstrb = '0; s_wdata = '0;
        repeat (3) @(posedge clk); #1;
        chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
        chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_link_up", {31'd0, link_up}, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_s_rdata", s_rdata, 32'd0);
        chk("rst_m_addr", m_addr, 32'd0);

        // timer 0..99 over 100 edges, pending on 100th, m_valid after 101st
        @(negedge clk); rst = 1'b0;
        n = 0;
        for (int i = 1; i <= 300; i++) begin
            @(posedge clk); #1;
            if (m_valid) begin n = i; break; end
        end
        chk("poll_start_cycle", n, 32'd101);
        chk("poll_addr", m_addr, 32'h0700_0004);
        chk("poll_wstrb", {28'd0, m_wstrb}, 32'd0);
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (!m_valid) break;
        end
        repeat (2) @(posedge clk); #1;
        chk("poll1_link_up", {31'd0, link_up}, 32'd1);
        chk("poll1_irq_masked", {31'd0, irq}, 32'd0);
        rd32("status1", STATUS, d);
        chk("status1", d, 32'h782D_0007);
        wr32("w1c1", STATUS, 32'h4);
        rd32("status2", STATUS, d);
        chk("status2", d, 32'h782D_0003);

        wr32("ctrl3", CTRL, 32'h3);
        rd32("ctrl_rd", CTRL, d);
        chk("ctrl_rd", d, 32'h3);
        bmsr_m = 16'h7809;
        p0 = poll_cnt;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (poll_cnt > p0) break;
        end
        chk("poll2_seen", {31'd0, poll_cnt > p0}, 32'd1);
        repeat (2) @(posedge clk); #1;
        chk("poll2_link_down", {31'd0, link_up}, 32'd0);
        chk("poll2_irq", {31'd0, irq}, 32'd1);
        rd32("status3", STATUS, d);
        chk("status3", d, 32'h7809_0004);
        wr32("w1c2", STATUS, 32'h4);
        chk("irq_cleared", {31'd0, irq}, 32'd0);

        wr32("ctrl_irq_only", CTRL, 32'h2);
        s0 = sr_cnt; c0 = cpu_cnt; p0 = poll_cnt;
        cpu_m = 32'h0000_2D78;
        rd32("cpu_rd", 32'h0700_0104, d);
        chk("cpu_rd_data", d, 32'h0000_2D78);
        repeat (3) @(posedge clk); #1;
        chk("cpu_rd_sready_pulses", sr_cnt - s0, 32'd1);
        chk("cpu_rd_txns", cpu_cnt - c0, 32'd1);
        chk("cpu_rd_no_poll", poll_cnt - p0, 32'd0);
        chk("cpu_rd_addr", cpu_addr_seen, 32'h0700_0104);
        chk("cpu_rd_wstrb", {28'd0, cpu_wstrb_seen}, 32'd0);
        wr32("cpu_wr", 32'h0700_0008, 32'h1234_5678);
        chk("cpu_wr_addr", cpu_addr_seen, 32'h0700_0008);
        chk("cpu_wr_data", cpu_wdata_seen, 32'h1234_5678);
        chk("cpu_wr_wstrb", {28'd0, cpu_wstrb_seen}, 32'hF);
        bus(32'h0900_0000, 4'd0, 32'd0, 20, d, ok);
        chk("unmapped_no_ready", {31'd0, ok}, 32'd0);

        wr32("ctrl_off", CTRL, 32'h0);
        n = 0;
        repeat (3 * 100) begin
            @(posedge clk); #1;
            if (m_valid) n++;
        end
        chk("disabled_no_mvalid", n, 32'd0);

        // CPU request lands on the cycle poll_pending is first seen by IDLE
        wr32("ctrl_on", CTRL, 32'h1);
        repeat (100) @(posedge clk);
        p0 = poll_cnt; s0 = sr_cnt;
        cpu_m = 32'hA5A5_0F0F;
        rd32("collide", 32'h0700_0010, d);
        chk("collide_data", d, 32'hA5A5_0F0F);
        chk("collide_poll_first", cpu_poll_mark, p0 + 1);
        repeat (3) @(posedge clk); #1;
        chk("collide_sready_once", sr_cnt - s0, 32'd1);
        chk("m_valid_after_ready", mv_viol, 32'd0);

        wr32("ctrl_off2", CTRL, 32'h0);
        resp_en = 1'b0;
        @(negedge clk);
        s_valid = 1'b1; s_addr = 32'h0700_0000; s_wstrb = 4'd0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (m_valid) break;
        end
        chk("midrst_mvalid_up", {31'd0, m_valid}, 32'd1);
        @(negedge clk); s_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_mvalid_drop", {31'd0, m_valid}, 32'd0);
        @(negedge clk); rst = 1'b0;
        s0 = sr_cnt;
        late_pulse = 1'b1;
        resp_en = 1'b1;
        repeat (4) @(posedge clk); #1;
        chk("late_ready_mvalid", {31'd0, m_valid}, 32'd0);
        chk("late_ready_no_sready", sr_cnt - s0, 32'd0);
        chk("midrst_link_up", {31'd0, link_up}, 32'd0);

`ifdef MDIO_POLL_TIMEOUT_EN
        wr32("ctrl_off3", CTRL, 32'h0);
        resp_en = 1'b0;
        bus(32'h0700_0020, 4'd0, 32'd0, 200, d, ok);
        chk("tmo_ack", {31'd0, ok}, 32'd1);
        chk("tmo_data", d, 32'hFFFF_FFFF);
        rd32("tmo_status", STATUS, d);
        chk("tmo_status_bit3", {31'd0, d[3]}, 32'd1);
        bus(32'h0700_0020, 4'd0, 32'd0, 60, d, ok);
        chk("halt_stalls_cpu", {31'd0, ok}, 32'd0);
        wr32("tmo_w1c", STATUS, 32'h8);
        resp_en = 1'b1;
        cpu_m = 32'h0BAD_F00D;
        rd32("after_halt", 32'h0700_0024, d);
        chk("after_halt_data", d, 32'h0BAD_F00D);
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
